spi_xfer_arbiter: RTL and testbench

Shares one SPI core between `NUM_REQ` local requesters. Each requester asks for single-byte transfers. The block grants requesters round-robin and drives a dedicated active-low chip select per requester. It loads the TX byte into the core, pulses the core's start strobe and waits for the core's finish indication. It then returns the received byte and either locks the bus for a burst or releases it after a programmable inter-frame gap. It sits between the register/host logic and `spi_core`, connecting to that core's `spi_dr_in`, `new_tx_in`, `finished_out` and `shift_out`.

---
 rtl/spi_xfer_arbiter_if.sv | 30 +++
 rtl/spi_xfer_arbiter.sv | 162 ++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// Requester-side and SPI-core-side signals of the SPI transfer arbiter.
// The slave modport is the arbiter's view; master is the requester and core view.
`timescale 1ns/1ps
interface spi_xfer_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]   req_in;
    logic [8*NUM_REQ-1:0] req_data_in;
    logic [NUM_REQ-1:0]   req_hold_in;
    logic [NUM_REQ-1:0]   grant_out;
    logic [NUM_REQ-1:0]   done_out;
    logic [NUM_REQ-1:0]   timeout_out;
    logic [7:0]           rx_data_out;
    logic [NUM_REQ-1:0]   cs_n_out;
    logic                 busy_out;
    logic                 new_tx_out;
    logic [7:0]           spi_dr_out;
    logic                 finished_in;
    logic [7:0]           shift_in;

    modport slave (
        input  req_in, req_data_in, req_hold_in, finished_in, shift_in,
        output grant_out, done_out, timeout_out, rx_data_out, cs_n_out,
        busy_out, new_tx_out, spi_dr_out
    );

    modport master (
        output req_in, req_data_in, req_hold_in, finished_in, shift_in,
        input  grant_out, done_out, timeout_out, rx_data_out, cs_n_out,
        busy_out, new_tx_out, spi_dr_out
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI core; grant 1 cycle after request, done 1 cycle after finish edge.
// Requesters hold req/data until done or timeout; bursts keep CS low while req_hold is asserted.
`timescale 1ns/1ps
module spi_xfer_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk_in,
    input  logic              rstn_in,
    spi_xfer_arbiter_if.slave bus
);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW   = $clog2(TIMEOUT);
    localparam int GAPN = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GW   = $clog2(GAPN + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [TW-1:0]      T_LAST   = TW'(TIMEOUT - 2);
    localparam logic [PW-1:0]      P_LAST   = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE, S_GAP} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PW-1:0]      r_gidx;
    logic [PW-1:0]      r_rr_ptr;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_tout;
    logic [7:0]         r_rx;
    logic [NUM_REQ-1:0] r_cs_n;
    logic               r_busy;
    logic               r_new_tx;
    logic [7:0]         r_spi_dr;
    logic               r_fin_q;
    logic [TW-1:0]      r_timer;
    logic [GW-1:0]      r_gap;

    logic               w_any;
    logic [PW-1:0]      w_sel;
    int                 w_idx;
    logic [7:0]         w_tx;
    logic               w_fin_edge;
    logic               w_hold;
    logic [PW-1:0]      w_next_ptr;

    // First requesting index at or after the round-robin pointer, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_any && bus.req_in[PW'(w_idx)]) begin
                w_any = 1'b1;
                w_sel = PW'(w_idx);
            end
        end
    end

    always_comb begin
        w_tx = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gidx == PW'(i)) w_tx = bus.req_data_in[8*i +: 8];
        end
    end

    // A finish level already high before WAIT never looks like an edge.
    assign w_fin_edge = bus.finished_in & ~r_fin_q;
    assign w_hold     = |(bus.req_in & bus.req_hold_in & r_grant);
    assign w_next_ptr = (r_gidx == P_LAST) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_done   <= '0;
            r_tout   <= '0;
            r_rx     <= 8'h00;
            r_cs_n   <= '1;
            r_busy   <= 1'b0;
            r_new_tx <= 1'b0;
            r_spi_dr <= 8'h00;
            r_fin_q  <= 1'b1;
            r_timer  <= '0;
            r_gap    <= '0;
        end else begin
            r_fin_q  <= bus.finished_in;
            r_done   <= '0;
            r_tout   <= '0;
            r_new_tx <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= ONE_HOT0 << w_sel;
                        r_gidx  <= w_sel;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_spi_dr <= w_tx;
                    r_cs_n   <= ~r_grant;
                    r_new_tx <= 1'b1;
                    r_state  <= S_START;
                end
                S_START: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= (r_timer == '1) ? r_timer : r_timer + 1'b1;
                    if (w_fin_edge) begin
                        r_rx    <= bus.shift_in;
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end else if (r_timer == T_LAST) begin
                        // Exits one cycle early so the pulse lands exactly TIMEOUT after START.
                        r_tout   <= r_grant;
                        r_cs_n   <= '1;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_gap    <= GW'(GAPN - 1);
                        r_state  <= S_GAP;
                    end
                end
                S_DONE: begin
                    if (w_hold) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_cs_n   <= '1;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_gap    <= GW'(GAPN - 1);
                        r_state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant_out   = r_grant;
    assign bus.done_out    = r_done;
    assign bus.timeout_out = r_tout;
    assign bus.rx_data_out = r_rx;
    assign bus.cs_n_out    = r_cs_n;
    assign bus.busy_out    = r_busy;
    assign bus.new_tx_out  = r_new_tx;
    assign bus.spi_dr_out  = r_spi_dr;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: directed scenarios, scoreboard of done/timeout events, SPI core model.
`timescale 1ns/1ps
module tb_spi_xfer_arbiter;
    typedef logic [12:0] ev_t;  // {is_timeout, who[3:0], rx[7:0]}

    logic clk;
    logic rstn;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  expq[$];

    bit       core_en = 1;
    int       core_lat = 10;
    logic [7:0] core_xor = 8'h00;
    logic     core_fin;
    logic [7:0] core_shift;
    logic     man_fin = 0;
    logic     man_sel = 0;
    logic [7:0] man_shift = 8'h00;
    bit       trk = 0;
    bit       cs_broke = 0;

    spi_xfer_arbiter_if #(.NUM_REQ(4)) bus();

    spi_xfer_arbiter #(.NUM_REQ(4), .GAP_CYCLES(2), .TIMEOUT(16)) dut (
        .clk_in (clk),
        .rstn_in(rstn),
        .bus    (bus)
    );

    assign bus.finished_in = core_fin | man_fin;
    assign bus.shift_in    = man_sel ? man_shift : core_shift;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic t, input logic [3:0] w, input logic [7:0] r);
        return {t, w, r};
    endfunction

    // Core model: answers each start strobe with spi_dr ^ core_xor, finish high for two cycles.
    initial begin
        logic [7:0] b;
        core_fin = 0;
        core_shift = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.new_tx_out && core_en) begin
                b = bus.spi_dr_out ^ core_xor;
                repeat (core_lat) @(posedge clk);
                #1;
                core_shift = b;
                core_fin = 1;
                @(posedge clk);
                @(posedge clk);
                #1 core_fin = 0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        if ((bus.done_out | bus.timeout_out) != 0) begin
            act = {|bus.timeout_out, bus.done_out | bus.timeout_out,
                   (|bus.timeout_out) ? 8'h00 : bus.rx_data_out};
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL evt_unexpected: got %0h expected no event", act);
            end else begin
                e = expq.pop_front();
                chk("evt", 32'(act), 32'(e));
            end
        end
    end

    always @(negedge clk) if (trk && bus.cs_n_out[2]) cs_broke = 1;

    task automatic wait_until(input int kind, input int maxc, input string name, output int at);
        bit hit;
        hit = 0;
        for (int n = 0; n < maxc && !hit; n++) begin
            @(negedge clk);
            case (kind)
                0: hit = bus.new_tx_out;
                1: hit = (bus.done_out != 0);
                2: hit = (bus.timeout_out != 0);
                3: hit = (bus.grant_out != 0);
                4: hit = !bus.busy_out;
                default: hit = (bus.grant_out == 0);
            endcase
        end
        at = cyc;
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: no event within %0d cycles, event required", name, maxc);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
    endtask

    logic [3:0] rr_exp [5];
    logic [7:0] rr_dat [4];

    initial begin
        int t0;
        int at;
        int gapn;
        rstn = 0;
        bus.req_in = '0;
        bus.req_hold_in = '0;
        bus.req_data_in = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bus.grant_out), 32'h0);
        chk("rst_cs", 32'(bus.cs_n_out), 32'hF);
        chk("rst_busy", 32'(bus.busy_out), 32'h0);
        chk("rst_newtx", 32'(bus.new_tx_out), 32'h0);
        chk("rst_dr", 32'(bus.spi_dr_out), 32'h0);
        chk("rst_rx", 32'(bus.rx_data_out), 32'h0);
        chk("rst_pulses", 32'({bus.done_out, bus.timeout_out}), 32'h0);
        rstn = 1;

        // Single requester
        core_xor = 8'h99;
        expq.push_back(mk(0, 4'b0010, 8'h3C));
        sync();
        t0 = cyc;
        bus.req_data_in[15:8] = 8'hA5;
        bus.req_in = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("single_grant", 32'(bus.grant_out), 32'h2);
        chk("single_busy", 32'(bus.busy_out), 32'h1);
        @(negedge clk);
        chk("single_cs", 32'(bus.cs_n_out), 32'hD);
        chk("single_newtx", 32'(bus.new_tx_out), 32'h1);
        chk("single_dr", 32'(bus.spi_dr_out), 32'hA5);
        @(negedge clk);
        chk("single_newtx_off", 32'(bus.new_tx_out), 32'h0);
        wait_until(1, 30, "single_done", at);
        chk("single_done_cyc", 32'(at - t0), 32'd13);
        bus.req_in = '0;
        @(negedge clk);
        chk("single_cs_rel", 32'(bus.cs_n_out), 32'hF);
        chk("single_grant_rel", 32'(bus.grant_out), 32'h0);
        wait_until(4, 20, "single_idle", at);

        // Round-robin, all four requesting
        do_reset();
        core_xor = 8'hF0;
        rr_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) bus.req_data_in[8*i +: 8] = rr_dat[i];
        for (int f = 0; f < 5; f++) expq.push_back(mk(0, rr_exp[f], rr_dat[f % 4] ^ 8'hF0));
        sync();
        bus.req_in = 4'hF;
        wait_until(3, 20, "rr_grant0", at);
        chk("rr_grant0", 32'(bus.grant_out), 32'(rr_exp[0]));
        for (int f = 1; f < 5; f++) begin
            wait_until(5, 60, "rr_release", at);
            gapn = 0;
            for (int n = 0; n < 50; n++) begin
                if (bus.grant_out != 0) break;
                if (bus.busy_out && bus.cs_n_out == 4'hF) gapn++;
                @(negedge clk);
            end
            chk($sformatf("rr_gap%0d", f), 32'(gapn), 32'd2);
            chk($sformatf("rr_grant%0d", f), 32'(bus.grant_out), 32'(rr_exp[f]));
            if (f == 4) bus.req_in = '0;
        end
        wait_until(1, 40, "rr_last_done", at);
        wait_until(4, 20, "rr_idle", at);

        // Locked burst from requester 2 while requester 0 waits
        core_xor = 8'h0F;
        expq.push_back(mk(0, 4'b0100, 8'h0E));
        expq.push_back(mk(0, 4'b0100, 8'h0D));
        expq.push_back(mk(0, 4'b0100, 8'h0C));
        expq.push_back(mk(0, 4'b0001, 8'hAF));
        sync();
        bus.req_data_in[7:0] = 8'hA0;
        bus.req_data_in[23:16] = 8'h01;
        bus.req_hold_in = 4'b0100;
        bus.req_in = 4'b0101;
        for (int b = 0; b < 3; b++) begin
            wait_until(0, 40, "burst_newtx", at);
            trk = 1;
            chk($sformatf("burst_cs%0d", b), 32'(bus.cs_n_out), 32'hB);
            chk($sformatf("burst_grant%0d", b), 32'(bus.grant_out), 32'h4);
            if (b == 2) bus.req_hold_in = '0;
            wait_until(1, 40, "burst_done", at);
            if (b < 2) bus.req_data_in[23:16] = 8'(b + 2);
        end
        trk = 0;
        chk("burst_cs_held", 32'(cs_broke), 32'h0);
        bus.req_in = 4'b0001;
        wait_until(3, 20, "burst_next_grant", at);
        chk("burst_next_grant", 32'(bus.grant_out), 32'h1);
        wait_until(1, 40, "burst_req0_done", at);
        bus.req_in = '0;
        wait_until(4, 20, "burst_idle", at);

        // Stale finish level held high before START
        core_en = 0;
        man_sel = 1;
        man_shift = 8'hEE;
        man_fin = 1;
        expq.push_back(mk(0, 4'b1000, 8'h9C));
        sync();
        bus.req_data_in[31:24] = 8'h77;
        bus.req_in = 4'b1000;
        wait_until(0, 20, "stale_newtx", at);
        gapn = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done_out != 0) gapn = 1;
        end
        chk("stale_no_done", 32'(gapn), 32'h0);
        sync();
        man_fin = 0;
        sync();
        man_shift = 8'h9C;
        man_fin = 1;
        t0 = cyc;
        wait_until(1, 10, "stale_done", at);
        chk("stale_done_cyc", 32'(at - t0), 32'd1);
        bus.req_in = '0;
        man_fin = 0;
        man_sel = 0;
        wait_until(4, 20, "stale_idle", at);

        // Timeout on requester 1, then requester 2 served
        core_xor = 8'h5A;
        expq.push_back(mk(1, 4'b0010, 8'h00));
        expq.push_back(mk(0, 4'b0100, 8'h3C));
        sync();
        bus.req_data_in[15:8] = 8'h55;
        bus.req_data_in[23:16] = 8'h66;
        bus.req_in = 4'b0110;
        wait_until(0, 20, "tout_newtx", at);
        t0 = at;
        wait_until(2, 40, "tout_pulse", at);
        chk("tout_cyc", 32'(at - t0), 32'd16);
        chk("tout_cs", 32'(bus.cs_n_out), 32'hF);
        bus.req_in = 4'b0100;
        core_en = 1;
        wait_until(3, 20, "tout_next_grant", at);
        chk("tout_next_grant", 32'(bus.grant_out), 32'h4);
        wait_until(1, 40, "tout_next_done", at);
        bus.req_in = '0;
        wait_until(4, 20, "tout_idle", at);

        // Reset in the middle of WAIT
        core_en = 0;
        core_xor = 8'h11;
        sync();
        bus.req_data_in[7:0] = 8'hC1;
        bus.req_data_in[31:24] = 8'hD3;
        bus.req_in = 4'b0001;
        wait_until(0, 20, "mrst_newtx", at);
        sync();
        rstn = 0;
        #2;
        chk("mrst_cs", 32'(bus.cs_n_out), 32'hF);
        chk("mrst_grant", 32'(bus.grant_out), 32'h0);
        chk("mrst_busy", 32'(bus.busy_out), 32'h0);
        bus.req_in = 4'b1001;
        expq.push_back(mk(0, 4'b0001, 8'hD0));
        expq.push_back(mk(0, 4'b1000, 8'hC2));
        core_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
        wait_until(3, 20, "mrst_grant_after", at);
        chk("mrst_grant_after", 32'(bus.grant_out), 32'h1);
        wait_until(1, 40, "mrst_done0", at);
        bus.req_in = 4'b1000;
        wait_until(1, 60, "mrst_done3", at);
        bus.req_in = '0;
        wait_until(4, 20, "mrst_idle", at);
        repeat (5) @(negedge clk);
        chk("evq_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
